// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: N-way round-robin ready/valid arbiter feeding one
// registered output stage tagged with the winning requester index.
// Ports: CLK, ASYNCRESETN (async, active low)
//   in_valid/in_ready/in_data  : N upstream lanes, lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready        : downstream handshake
//   out_data/out_id            : registered payload and its source index
//   grant_count                : per-lane accepted-transfer counters
// Build option: HANDSHAKE_RR_ARBITER_STATS_EN enables saturating grant
// counters; without it grant_count is tied to zero.
module handshake_rr_arbiter #(
  parameter int N = 3,
  parameter int WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  localparam int ID_WIDTH = $clog2(N)
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic [N*WIDTH-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_WIDTH-1:0]    out_id,
  output logic [N*CNT_WIDTH-1:0] grant_count
);

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_vld;
  logic [WIDTH-1:0]    win_data;
  logic                can_accept;
  logic                up_xfer;

  // (p + k) mod N, where N need not be a power of two
  function automatic logic [ID_WIDTH-1:0] wrap(
    input logic [ID_WIDTH-1:0] p,
    input int                  k
  );
    logic [ID_WIDTH:0] s;
    s = {1'b0, p} + (ID_WIDTH+1)'(k);
    if (s >= (ID_WIDTH+1)'(N))
      s = s - (ID_WIDTH+1)'(N);
    return s[ID_WIDTH-1:0];
  endfunction

  // Scan from the far end back toward ptr so the
  // closest valid lane is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[wrap(ptr, k)]) begin
        win_vld = 1'b1;
        win_id  = wrap(ptr, k);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++)
      if (win_id == ID_WIDTH'(i))
        win_data = in_data[i*WIDTH +: WIDTH];
  end

  assign can_accept = ~out_valid | out_ready;
  assign up_xfer    = can_accept & win_vld & ASYNCRESETN;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = up_xfer & (win_id == ID_WIDTH'(i));
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (up_xfer) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_id    <= win_id;
      ptr       <= wrap(win_id, 1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HANDSHAKE_RR_ARBITER_STATS_EN
  logic [CNT_WIDTH-1:0] cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_cnt
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN)
        cnt[g] <= '0;
      else if (up_xfer && win_id == ID_WIDTH'(g) && cnt[g] != '1)
        cnt[g] <= cnt[g] + 1'b1;
    end
    assign grant_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb_handshake_rr_arbiter: directed scoreboard bench for the
// round-robin arbiter (N=3, WIDTH=4, CNT_WIDTH=8).
`timescale 1ns/100ps
module tb_handshake_rr_arbiter;

  localparam int N = 3;
  localparam int W = 4;
  localparam int CW = 8;
`ifdef HANDSHAKE_RR_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          ASYNCRESETN;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_id;
  logic [N*CW-1:0] grant_count;

  int tests = 0;
  int failed = 0;
  int exp_cnt [N];
  logic [5:0] exp_q [$];

  handshake_rr_arbiter #(.N(N), .WIDTH(W), .CNT_WIDTH(CW)) dut (
    .CLK(CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_id(out_id),
    .grant_count(grant_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(int id, logic [3:0] d);
    logic [1:0] i2;
    i2 = 2'(id);
    exp_q.push_back({i2, d});
    if (exp_cnt[id] < 255)
      exp_cnt[id]++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_counts(string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_cnt%0d", tag, i),
          32'(grant_count[i*CW +: CW]),
          STATS ? 32'(exp_cnt[i]) : 32'd0);
  endtask

  always @(negedge CLK) begin
    if (ASYNCRESETN && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_out: id %0d data %0h, none expected",
                 out_id, out_data);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("out_id", 32'(out_id), 32'(e[5:4]));
        chk("out_data", 32'(out_data), 32'(e[3:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    ASYNCRESETN = 1'b0;
    in_valid = 3'b111;
    in_data = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(grant_count), 32'd0);
    in_valid = '0;
    step();
    step();
    ASYNCRESETN = 1'b1;

    // Fill the register, then reset mid-cycle
    in_valid = 3'b001;
    in_data = {4'h0, 4'h0, 4'h5};
    out_ready = 1'b0;
    #1;
    chk("first_in_ready", 32'(in_ready), 32'b001);
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_data", 32'(out_data), 32'h5);
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_id", 32'(out_id), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_cnt", 32'(grant_count), 32'd0);
    in_valid = '0;
    step();
    ASYNCRESETN = 1'b1;

    // Round robin across all three, full rate
    in_data = {4'h3, 4'h2, 4'h1};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 4'(i + 1));
    in_valid = 3'b111;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("no_bubble", 32'(out_valid), 32'd1);
    end
    in_valid = '0;
    step();
    chk("rr_drained", 32'(out_valid), 32'd0);
    chk_counts("rr");

    // Lone requester 2 from ptr=0, then 0 before 1
    in_data = {4'hA, 4'h9, 4'h8};
    push(2, 4'hA);
    in_valid = 3'b100;
    #1;
    chk("lone2_ready", 32'(in_ready), 32'b100);
    step();
    chk("lone2_id", 32'(out_id), 32'd2);
    push(0, 4'h8);
    push(1, 4'h9);
    in_valid = 3'b011;
    #1;
    chk("wrap_ready0", 32'(in_ready), 32'b001);
    step();
    chk("wrap_ready1", 32'(in_ready), 32'b010);
    step();
    in_valid = '0;
    step();
    chk("wrap_drained", 32'(out_valid), 32'd0);

    // Backpressure with 0 and 1 contending (ptr=2)
    in_data = {4'h0, 4'h6, 4'h5};
    out_ready = 1'b0;
    push(0, 4'h5);
    in_valid = 3'b011;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'(out_data), 32'h5);
      chk("bp_id", 32'(out_id), 32'd0);
      step();
    end
    push(1, 4'h6);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b010);
    step();
    in_valid = '0;
    chk("bp_reload_valid", 32'(out_valid), 32'd1);
    chk("bp_reload_id", 32'(out_id), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Transient valid on lane 1 while stalled (ptr=2)
    out_ready = 1'b0;
    in_data = {4'h0, 4'hE, 4'h7};
    push(0, 4'h7);
    in_valid = 3'b001;
    step();
    in_valid = 3'b010;
    #1;
    chk("drop_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = '0;
    step();
    out_ready = 1'b1;
    step();
    chk("drop_drained", 32'(out_valid), 32'd0);
    step();
    chk("drop_no_spurious", 32'(out_valid), 32'd0);
    chk_counts("drop");

    // Saturation: lane 0 alone for 300 transfers
    in_data = {4'h0, 4'h0, 4'h4};
    for (int c = 0; c < 300; c++) push(0, 4'h4);
    in_valid = 3'b001;
    for (int c = 0; c < 300; c++) step();
    in_valid = '0;
    step();
    step();
    chk("sat_drained", 32'(out_valid), 32'd0);
    chk_counts("sat");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/handshake_rr_arbiter.md
# handshake_rr_arbiter

Round-robin arbiter that shares one downstream ready/valid channel between N upstream ready/valid requesters, each carrying a WIDTH-bit payload. It sits in front of the shared `bar_foo_RTL` datapath input: requesters 0..N-1 (the `handshake_arr` lanes) compete and the winner's payload is forwarded through a one-entry registered output stage tagged with its requester index. Fair rotation, full throughput (one transfer per cycle) and optional per-requester grant statistics.

## Interface
- N, 3, number of requesters (2..8)
- WIDTH, 4, payload width in bits
- CNT_WIDTH, 8, width of each grant-statistics counter
- ID_WIDTH, $clog2(N), width of requester index (derived, not overridable)

- CLK  in  1  clock, all state on rising edge
- ASYNCRESETN  in  1  asynchronous active-low reset
- in_valid  in  N  per-requester valid
- in_ready  out  N  per-requester ready, combinational
- in_data  in  N*WIDTH  payloads, requester i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output stage holds a payload
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  registered payload
- out_id  out  ID_WIDTH  index of requester that supplied out_data
- grant_count  out  N*CNT_WIDTH  per-requester accepted-transfer counters, requester i at [i*CNT_WIDTH +: CNT_WIDTH]

## Operation
- State: output register (out_valid, out_data, out_id), priority pointer ptr (ID_WIDTH, range 0..N-1), grant counters.
- can_accept = ~out_valid | out_ready.
- Winner: first requester with in_valid set scanning ptr, ptr+1, ..., wrapping modulo N (not modulo 2^ID_WIDTH). No valid -> no winner.
- in_ready[i] = can_accept & (i == winner) & in_valid[i]; at most one bit set. Non-winners see ready low.
- Upstream transfer on requester i when in_valid[i] & in_ready[i]: next cycle out_valid=1, out_data=in_data[i], out_id=i, ptr=(i+1) mod N.
- Downstream transfer when out_valid & out_ready: if no upstream transfer same cycle, out_valid clears; out_data/out_id hold last values.
- Simultaneous downstream and upstream transfer: register reloads with new payload, out_valid stays 1 (no bubble).
- out_valid & ~out_ready: register, ptr and in_ready all frozen (in_ready=0); out_data/out_id stable until accepted.
- ptr changes only on upstream transfer; a requester that stays valid is served within N transfers.
- Requesters may drop valid before being granted; no lock on a pending grant.

## Timing
- Reset (ASYNCRESETN low, immediate): out_valid=0, out_data=0, out_id=0, ptr=0, all grant_count=0; in_ready=0 during reset. Reset mid-transfer discards held payload.
- Release synchronized externally; first arbitration on first rising edge after deassertion.
- Latency: upstream accept at edge k -> out_valid high after edge k, visible in cycle k+1.
- Throughput: one payload per cycle sustained when out_ready held high.
- No combinational path from in_valid/in_data to out_*; in_ready depends combinationally on in_valid, out_valid, out_ready.

## Configuration
- HANDSHAKE_RR_ARBITER_STATS_EN defined: grant_count[i] increments on each upstream transfer from requester i, saturating at 2^CNT_WIDTH-1 (no wrap); cleared only by reset.
- Not defined: counter logic absent, grant_count tied to 0; all other behaviour identical.

## Test plan
- Reset: assert ASYNCRESETN low mid-cycle with out_valid=1 -> out_valid, out_data, out_id, in_ready, grant_count go 0 immediately.
- All three valid, out_ready=1, payloads 0x1/0x2/0x3 held -> out_id sequence 0,1,2,0,1,2 with out_data 1,2,3,..., one per cycle, no bubbles.
- Only requester 2 valid from reset (ptr=0) -> granted first cycle, out_id=2, ptr becomes 0 (wrap); then requesters 0 and 1 valid -> 0 served before 1.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles, requesters 0,1 valid -> in_ready=0 throughout, out_data/out_id constant; out_ready=1 -> drain and reload same cycle, out_valid stays 1.
- Valid drop: requester 1 valid one cycle while register full and stalled, then drops -> never granted, grant_count[1] unchanged, no spurious out_valid.
- STATS_EN on, CNT_WIDTH=8, requester 0 alone valid 300 cycles with out_ready=1 -> grant_count[0]=255 saturated, others 0; STATS_EN off -> all counts 0.
